// File: rtl/instruction_cache_nway.sv
// N-way set-associative L1 instruction cache, true-LRU replacement, INVALID/SHARED line states,
// fetch handshake, blocking L2 miss handshake, snoop invalidation and saturating statistics.
module instruction_cache_nway #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INDEX_BITS  = 14,
    parameter int OFFSET_BITS = 6,
    parameter int WAYS        = 4,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                              Clock,
    input  logic                              Reset,
    input  logic                              fetch_valid,
    input  logic [ADDR_WIDTH-1:0]             fetch_addr,
    output logic                              fetch_ready,
    output logic                              resp_valid,
    output logic                              resp_hit,
    output logic                              l2_req,
    output logic [1:0]                        l2_cmd,
    output logic [ADDR_WIDTH-OFFSET_BITS-1:0] l2_addr,
    input  logic                              l2_ack,
    input  logic                              snoop_valid,
    input  logic [ADDR_WIDTH-1:0]             snoop_addr,
    output logic [CNT_WIDTH-1:0]              hit,
    output logic [CNT_WIDTH-1:0]              miss,
    output logic [CNT_WIDTH-1:0]              reads
);
    localparam int TAG_BITS  = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
    localparam int LINE_BITS = ADDR_WIDTH - OFFSET_BITS;
    localparam int SETS      = 2 ** INDEX_BITS;
    localparam int LOG_WAYS  = $clog2(WAYS);

    typedef enum logic {IDLE, MISS} state_t;

    state_t state_q, state_d;

    logic [TAG_BITS-1:0]  tag_q   [SETS][WAYS];
    logic                 valid_q [SETS][WAYS];
    logic [LOG_WAYS-1:0]  age_q   [SETS][WAYS];

    logic [LINE_BITS-1:0] miss_line_q;
    logic                 pend_inv_q;

    logic                  accept;
    logic [INDEX_BITS-1:0] f_idx, m_idx, s_idx;
    logic [TAG_BITS-1:0]   f_tag, m_tag, s_tag;
    logic                  lk_hit;
    logic [LOG_WAYS-1:0]   lk_way;
    logic [LOG_WAYS-1:0]   vic_way;
    logic                  vic_found;
    logic                  fill;
    logic                  snoop_pending;
    logic                  upd_en;
    logic [INDEX_BITS-1:0] upd_idx;
    logic [LOG_WAYS-1:0]   upd_way;
    logic [LOG_WAYS-1:0]   upd_age;
    logic [LOG_WAYS-1:0]   new_age [WAYS];
    logic                  unused_offsets;

    assign unused_offsets = ^{fetch_addr[OFFSET_BITS-1:0], snoop_addr[OFFSET_BITS-1:0]};

    assign accept = fetch_valid && (state_q == IDLE);
    assign fill   = (state_q == MISS) && l2_ack;
    assign f_idx  = fetch_addr[OFFSET_BITS +: INDEX_BITS];
    assign f_tag  = fetch_addr[ADDR_WIDTH-1 -: TAG_BITS];
    assign s_idx  = snoop_addr[OFFSET_BITS +: INDEX_BITS];
    assign s_tag  = snoop_addr[ADDR_WIDTH-1 -: TAG_BITS];
    assign m_idx  = miss_line_q[INDEX_BITS-1:0];
    assign m_tag  = miss_line_q[LINE_BITS-1 -: TAG_BITS];

    assign snoop_pending = snoop_valid && (state_q == MISS) &&
                           (snoop_addr[ADDR_WIDTH-1:OFFSET_BITS] == miss_line_q);

    assign fetch_ready = (state_q == IDLE);
    assign l2_req      = (state_q == MISS);
    assign l2_cmd      = l2_req ? 2'b01 : 2'b00;
    assign l2_addr     = l2_req ? miss_line_q : 'z;

    always_comb begin
        lk_hit = 1'b0;
        lk_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[f_idx][w] && (tag_q[f_idx][w] == f_tag)) begin
                lk_hit = 1'b1;
                lk_way = LOG_WAYS'(w);
            end
        end
    end

    // Victim: lowest-index invalid way, otherwise the least recently used one.
    always_comb begin
        vic_found = 1'b0;
        vic_way   = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!vic_found && !valid_q[m_idx][w]) begin
                vic_found = 1'b1;
                vic_way   = LOG_WAYS'(w);
            end
        end
        if (!vic_found) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (age_q[m_idx][w] == LOG_WAYS'(WAYS - 1)) vic_way = LOG_WAYS'(w);
            end
        end
    end

    always_comb begin
        upd_en  = 1'b0;
        upd_idx = f_idx;
        upd_way = lk_way;
        if (accept && lk_hit) begin
            upd_en = 1'b1;
        end else if (fill) begin
            upd_en  = 1'b1;
            upd_idx = m_idx;
            upd_way = vic_way;
        end
        upd_age = age_q[upd_idx][upd_way];
        for (int unsigned w = 0; w < WAYS; w++) begin
            new_age[w] = age_q[upd_idx][w];
            if (LOG_WAYS'(w) == upd_way)          new_age[w] = '0;
            else if (age_q[upd_idx][w] < upd_age) new_age[w] = age_q[upd_idx][w] + LOG_WAYS'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && !lk_hit) state_d = MISS;
            MISS:    if (l2_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    tag_q[s][w]   <= '0;
                    valid_q[s][w] <= 1'b0;
                    age_q[s][w]   <= LOG_WAYS'(w);
                end
            end
            resp_valid  <= 1'b0;
            resp_hit    <= 1'b0;
            hit         <= '0;
            miss        <= '0;
            reads       <= '0;
            miss_line_q <= '0;
            pend_inv_q  <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            if (snoop_valid) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    if (valid_q[s_idx][w] && (tag_q[s_idx][w] == s_tag)) valid_q[s_idx][w] <= 1'b0;
                end
            end
            if (accept) begin
                if (reads != '1) reads <= reads + CNT_WIDTH'(1);
                if (lk_hit) begin
                    resp_valid <= 1'b1;
                    resp_hit   <= 1'b1;
                    if (hit != '1) hit <= hit + CNT_WIDTH'(1);
                end else begin
                    if (miss != '1) miss <= miss + CNT_WIDTH'(1);
                    miss_line_q <= fetch_addr[ADDR_WIDTH-1:OFFSET_BITS];
                    pend_inv_q  <= 1'b0;
                end
            end
            if (snoop_pending) pend_inv_q <= 1'b1;
            // Fill write comes after the snoop clear so the installed state wins for the victim way.
            if (fill) begin
                tag_q[m_idx][vic_way]   <= m_tag;
                valid_q[m_idx][vic_way] <= !(pend_inv_q || snoop_pending);
                resp_valid              <= 1'b1;
                resp_hit                <= 1'b0;
            end
            if (upd_en) begin
                for (int unsigned w = 0; w < WAYS; w++) age_q[upd_idx][w] <= new_age[w];
            end
        end
    end
endmodule

// File: tb/tb_instruction_cache_nway.sv
// Self-checking bench: directed scenarios plus randomized traffic against a recency-list cache model.
module tb_instruction_cache_nway;
    localparam int AW = 32, IB = 6, OB = 6, NW = 4, CW = 4;
    localparam int NSETS = 64;
    localparam int CMAX = 15;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          fetch_valid = 1'b0;
    logic [AW-1:0] fetch_addr = '0;
    logic          fetch_ready, resp_valid, resp_hit, l2_req;
    logic [1:0]    l2_cmd;
    logic [AW-OB-1:0] l2_addr;
    logic          l2_ack = 1'b0;
    logic          snoop_valid = 1'b0;
    logic [AW-1:0] snoop_addr = '0;
    logic [CW-1:0] hit, miss, reads;

    int tests = 0;
    int fails = 0;

    instruction_cache_nway #(
        .ADDR_WIDTH(AW), .INDEX_BITS(IB), .OFFSET_BITS(OB), .WAYS(NW), .CNT_WIDTH(CW)
    ) dut (
        .Clock(Clock), .Reset(Reset), .fetch_valid(fetch_valid), .fetch_addr(fetch_addr),
        .fetch_ready(fetch_ready), .resp_valid(resp_valid), .resp_hit(resp_hit),
        .l2_req(l2_req), .l2_cmd(l2_cmd), .l2_addr(l2_addr), .l2_ack(l2_ack),
        .snoop_valid(snoop_valid), .snoop_addr(snoop_addr),
        .hit(hit), .miss(miss), .reads(reads)
    );

    always #5 Clock = ~Clock;

    // Model: per set, line tags/valids per way and a recency list of ways (MRU first).
    bit [19:0] m_tag [NSETS][NW];
    bit        m_val [NSETS][NW];
    int        m_ord [NSETS][NW];
    int        m_hit, m_miss, m_reads;

    function automatic int sat(int v);
        return (v < CMAX) ? v + 1 : CMAX;
    endfunction

    function automatic void m_reset();
        for (int s = 0; s < NSETS; s++)
            for (int i = 0; i < NW; i++) begin
                m_tag[s][i] = '0; m_val[s][i] = 1'b0; m_ord[s][i] = i;
            end
        m_hit = 0; m_miss = 0; m_reads = 0;
    endfunction

    function automatic void m_touch(int s, int w);
        int p = 0;
        for (int i = 0; i < NW; i++) if (m_ord[s][i] == w) p = i;
        for (int i = p; i > 0; i--) m_ord[s][i] = m_ord[s][i-1];
        m_ord[s][0] = w;
    endfunction

    function automatic int m_find(int s, bit [19:0] t);
        int r = -1;
        for (int i = 0; i < NW; i++) if (m_val[s][i] && m_tag[s][i] == t) r = i;
        return r;
    endfunction

    function automatic int m_victim(int s);
        for (int i = 0; i < NW; i++) if (!m_val[s][i]) return i;
        return m_ord[s][NW-1];
    endfunction

    function automatic void m_snoop(logic [31:0] a);
        int w = m_find(int'((a >> 6) & 63), a[31:12]);
        if (w >= 0) m_val[(a >> 6) & 63][w] = 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk_counters();
        chk("hit_cnt", hit, m_hit);
        chk("miss_cnt", miss, m_miss);
        chk("reads_cnt", reads, m_reads);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        m_reset();
        chk("rst_ready", fetch_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_l2_req", l2_req, 0);
        chk("rst_l2_cmd", l2_cmd, 0);
        chk_counters();
    endtask

    // snp_cyc: -1 none, 0 with the lookup, c>=1 during the c-th miss cycle.
    task automatic fetch(input logic [31:0] a, input int ack_delay, input int exp_hit,
                         input int snp_cyc, input logic [31:0] snp_a, input bit noise);
        int s, w, v;
        bit [19:0] t;
        bit pend_inv;
        s = int'((a >> 6) & 63);
        t = a[31:12];
        chk("pre_ready", fetch_ready, 1);
        fetch_valid = 1'b1;
        fetch_addr  = a;
        if (snp_cyc == 0) begin snoop_valid = 1'b1; snoop_addr = snp_a; end
        step();
        fetch_valid = 1'b0;
        snoop_valid = 1'b0;
        m_reads = sat(m_reads);
        w = m_find(s, t);
        if (exp_hit >= 0) chk("directed_hit", resp_hit, exp_hit);
        if (w >= 0) begin
            m_hit = sat(m_hit);
            m_touch(s, w);
            if (snp_cyc == 0) m_snoop(snp_a);
            chk("hit_resp_valid", resp_valid, 1);
            chk("hit_resp_hit", resp_hit, 1);
        end else begin
            m_miss = sat(m_miss);
            if (snp_cyc == 0) m_snoop(snp_a);
            chk("miss_no_resp", resp_valid, 0);
            pend_inv = 1'b0;
            for (int c = 1; c <= ack_delay + 1; c++) begin
                chk("l2_req", l2_req, 1);
                chk("l2_cmd", l2_cmd, 2'b01);
                chk("l2_addr", l2_addr, a >> 6);
                chk("miss_ready", fetch_ready, 0);
                if (c > 1) chk("miss_resp_valid", resp_valid, 0);
                if (noise) begin fetch_valid = 1'($urandom_range(0, 1)); fetch_addr = $urandom; end
                if (c == ack_delay + 1) l2_ack = 1'b1;
                if (c == snp_cyc) begin snoop_valid = 1'b1; snoop_addr = snp_a; end
                step();
                l2_ack = 1'b0; snoop_valid = 1'b0; fetch_valid = 1'b0;
                if (c == snp_cyc && (snp_a >> 6) == (a >> 6)) pend_inv = 1'b1;
                if (c == ack_delay + 1) begin
                    v = m_victim(s);
                    m_tag[s][v] = t;
                    m_val[s][v] = !pend_inv;
                    m_touch(s, v);
                end
                if (c == snp_cyc && (snp_a >> 6) != (a >> 6)) m_snoop(snp_a);
            end
            chk("fill_resp_valid", resp_valid, 1);
            chk("fill_resp_hit", resp_hit, 0);
            chk("fill_l2_req", l2_req, 0);
        end
        chk_counters();
    endtask

    task automatic snoop(input logic [31:0] a);
        snoop_valid = 1'b1;
        snoop_addr  = a;
        step();
        snoop_valid = 1'b0;
        m_snoop(a);
        chk("snoop_no_resp", resp_valid, 0);
        chk_counters();
    endtask

    function automatic logic [31:0] pool_addr();
        logic [31:0] t, s, o;
        t = $urandom_range(0, 5);
        s = $urandom_range(0, 3);
        o = $urandom_range(0, 63);
        return (t << 12) | (s << 6) | o;
    endfunction

    initial begin
        logic [31:0] ra, sa;
        int op, dly, sc;
        step();
        Reset = 1'b0;

        // Basic miss then hit
        do_reset();
        fetch(32'h0000_1040, 2, 0, -1, '0, 1'b0);
        fetch(32'h0000_1040, 0, 1, -1, '0, 1'b0);
        chk("t1_hit", hit, 1);
        chk("t1_miss", miss, 1);
        chk("t1_reads", reads, 2);

        // Snoop invalidates a filled line
        snoop(32'h0000_1040);
        fetch(32'h0000_1040, 1, 0, -1, '0, 1'b0);
        chk("t3_miss", miss, 2);

        // Snoop with a same-cycle hit: hit reported, line ends invalid
        fetch(32'h0000_1040, 0, 1, 0, 32'h0000_1044, 1'b0);
        fetch(32'h0000_1040, 0, 0, -1, '0, 1'b0);

        // Snoop of the pending line while waiting for L2
        fetch(32'h0000_2080, 2, 0, 1, 32'h0000_2090, 1'b0);
        fetch(32'h0000_2080, 0, 0, -1, '0, 1'b0);

        // LRU replacement in set 0
        do_reset();
        for (int i = 1; i <= 4; i++) fetch(32'(i) << 12, 0, 0, -1, '0, 1'b0);
        fetch(32'h0000_1000, 0, 1, -1, '0, 1'b0);
        fetch(32'h0000_5000, 1, 0, -1, '0, 1'b0);
        fetch(32'h0000_1000, 0, 1, -1, '0, 1'b0);
        fetch(32'h0000_3000, 0, 1, -1, '0, 1'b0);
        fetch(32'h0000_4000, 0, 1, -1, '0, 1'b0);
        fetch(32'h0000_2000, 0, 0, -1, '0, 1'b0);

        // Reset in the middle of a miss; a late ack is ignored
        do_reset();
        fetch_valid = 1'b1; fetch_addr = 32'h0000_3000;
        step();
        fetch_valid = 1'b0;
        chk("t5_pre_req", l2_req, 1);
        step();
        do_reset();
        l2_ack = 1'b1;
        step();
        l2_ack = 1'b0;
        chk("t5_late_ack_resp", resp_valid, 0);
        chk("t5_late_ack_req", l2_req, 0);
        chk("t5_late_ack_ready", fetch_ready, 1);
        fetch(32'h0000_3000, 0, 0, -1, '0, 1'b0);

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 400; n++) begin
            op = $urandom_range(0, 9);
            if (op < 6) begin
                ra  = pool_addr();
                dly = $urandom_range(0, 3);
                sc  = -1;
                sa  = '0;
                if ($urandom_range(0, 3) == 0) begin
                    sc = $urandom_range(0, dly + 1);
                    sa = ($urandom_range(0, 1) == 1) ? ((ra & 32'hFFFF_FFC0) | 32'($urandom_range(0, 63)))
                                                     : pool_addr();
                end
                fetch(ra, dly, -1, sc, sa, 1'($urandom_range(0, 1)));
            end else if (op < 8) begin
                snoop(pool_addr());
            end else begin
                l2_ack = (op == 8);
                step();
                l2_ack = 1'b0;
                chk("idle_resp_valid", resp_valid, 0);
                chk("idle_ready", fetch_ready, 1);
                chk("idle_l2_req", l2_req, 0);
            end
        end

        // Counter saturation
        do_reset();
        fetch(32'h0000_1040, 0, 0, -1, '0, 1'b0);
        for (int i = 0; i < 17; i++) fetch(32'h0000_1040, 0, 1, -1, '0, 1'b0);
        chk("t6_hit_sat", hit, 4'hF);
        chk("t6_reads_sat", reads, 4'hF);
        chk("t6_miss", miss, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
